// File: rtl/dca_mru_block_mover.sv
// Block mover for the MRU execution path: loads an N x N block from LSU0 (or zero-fills it),
// then streams it out row by row, optionally transposed.
//
// state | meaning
// IDLE  | waiting for a step instruction; step_ready high
// LOAD  | accepting N load rows from LSU0 into the block buffer
// STORE | emitting N store rows from the buffer, transposed when tr is latched
module dca_mru_block_mover #(
    parameter int MATRIX_SIZE   = 8,
    parameter int BW_DATA       = 32,
    parameter int BW_OPCODE     = 8,
    parameter int IDX_TRANSPOSE = 0,
    parameter int IDX_LSU0_REQ  = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           step_valid,
    output logic                           step_ready,
    input  logic [BW_OPCODE:0]             step_inst,
    input  logic                           ld_valid,
    output logic                           ld_ready,
    input  logic [MATRIX_SIZE*BW_DATA-1:0] ld_row,
    output logic                           ld_done,
    output logic                           st_valid,
    input  logic                           st_ready,
    output logic [MATRIX_SIZE*BW_DATA-1:0] st_row,
    output logic                           last_done,
    output logic                           busy
);
    localparam int N  = MATRIX_SIZE;
    localparam int RW = (N > 1) ? $clog2(N) : 1;
    localparam logic [RW-1:0] RCNT_LAST = RW'(N - 1);

    typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;

    state_t             state_q, state_d;
    logic [RW-1:0]      rcnt_q, rcnt_d;
    logic               tr_q, lq_q, last_q;
    logic               ld_done_d, last_done_d;
    logic [BW_DATA-1:0] blk_buf [N][N];

    always_comb begin
        state_d     = state_q;
        rcnt_d      = rcnt_q;
        ld_done_d   = 1'b0;
        last_done_d = 1'b0;
        step_ready  = 1'b0;
        ld_ready    = 1'b0;
        st_valid    = 1'b0;
        case (state_q)
            IDLE: begin
                step_ready = 1'b1;
                if (step_valid) begin
                    rcnt_d  = '0;
                    state_d = step_inst[IDX_LSU0_REQ] ? LOAD : STORE;
                end
            end
            LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    rcnt_d = rcnt_q + RW'(1);
                    if (rcnt_q == RCNT_LAST) begin
                        rcnt_d    = '0;
                        state_d   = STORE;
                        ld_done_d = 1'b1;
                    end
                end
            end
            STORE: begin
                st_valid = 1'b1;
                if (st_ready) begin
                    rcnt_d = rcnt_q + RW'(1);
                    if (rcnt_q == RCNT_LAST) begin
                        rcnt_d      = '0;
                        state_d     = IDLE;
                        last_done_d = last_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rcnt_q    <= '0;
            tr_q      <= 1'b0;
            lq_q      <= 1'b0;
            last_q    <= 1'b0;
            ld_done   <= 1'b0;
            last_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
            ld_done   <= ld_done_d;
            last_done <= last_done_d;
            if (step_valid && step_ready) begin
                tr_q   <= step_inst[IDX_TRANSPOSE];
                lq_q   <= step_inst[IDX_LSU0_REQ];
                last_q <= step_inst[BW_OPCODE];
            end
        end
    end

    // Buffer has no reset: every element is rewritten (load or zero-fill) before it is read.
    always_ff @(posedge clk) begin
        if (step_valid && step_ready && !step_inst[IDX_LSU0_REQ]) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    blk_buf[r][c] <= '0;
                end
            end
        end else if (ld_valid && ld_ready) begin
            for (int c = 0; c < N; c++) begin
                blk_buf[rcnt_q][c] <= ld_row[c*BW_DATA +: BW_DATA];
            end
        end
    end

    always_comb begin
        st_row = '0;
        for (int c = 0; c < N; c++) begin
            st_row[c*BW_DATA +: BW_DATA] = tr_q ? blk_buf[c][rcnt_q] : blk_buf[rcnt_q][c];
        end
    end

endmodule

// File: tb/tb_dca_mru_block_mover.sv
// Self-checking bench for dca_mru_block_mover with N=4, 8-bit elements.
module tb_dca_mru_block_mover;
    localparam int N   = 4;
    localparam int BW  = 8;
    localparam int BWO = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              step_valid;
    logic              step_ready;
    logic [BWO:0]      step_inst;
    logic              ld_valid;
    logic              ld_ready;
    logic [N*BW-1:0]   ld_row;
    logic              ld_done;
    logic              st_valid;
    logic              st_ready;
    logic [N*BW-1:0]   st_row;
    logic              last_done;
    logic              busy;

    int n_checks = 0;
    int n_pass   = 0;
    logic [BW-1:0] mat [N][N];

    always #5 clk = ~clk;

    dca_mru_block_mover #(
        .MATRIX_SIZE(N), .BW_DATA(BW), .BW_OPCODE(BWO),
        .IDX_TRANSPOSE(0), .IDX_LSU0_REQ(1)
    ) dut (
        .clk(clk), .rst(rst),
        .step_valid(step_valid), .step_ready(step_ready), .step_inst(step_inst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_row(ld_row), .ld_done(ld_done),
        .st_valid(st_valid), .st_ready(st_ready), .st_row(st_row),
        .last_done(last_done), .busy(busy)
    );

    task automatic set_pattern();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                mat[r][c] = 8'(16 * r + c);
    endtask

    task automatic set_random();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                mat[r][c] = 8'($urandom);
    endtask

    function automatic logic [N*BW-1:0] mat_row(input int r);
        logic [N*BW-1:0] v;
        for (int c = 0; c < N; c++) v[c*BW +: BW] = mat[r][c];
        return v;
    endfunction

    // Expected store row: zero block, the matrix row, or the matrix column.
    function automatic logic [N*BW-1:0] exp_store(input int r, input bit tr, input bit lq);
        logic [N*BW-1:0] v;
        for (int c = 0; c < N; c++)
            v[c*BW +: BW] = !lq ? 8'h00 : (tr ? mat[c][r] : mat[r][c]);
        return v;
    endfunction

    // Unrelated opcode bits are randomised; only tr/lq may matter.
    function automatic logic [BWO:0] make_inst(input bit last, input bit tr, input bit lq);
        logic [BWO-1:0] op;
        op    = BWO'($urandom);
        op[0] = tr;
        op[1] = lq;
        return {last, op};
    endfunction

    task automatic test_reset();
        rst = 1'b1; step_valid = 1'b0; step_inst = '0;
        ld_valid = 1'b0; ld_row = '0; st_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (step_ready !== 1'b1) $display("FAIL reset_step_ready got %b want 1", step_ready); else n_pass++;
        n_checks++; if (ld_ready !== 1'b0) $display("FAIL reset_ld_ready got %b want 0", ld_ready); else n_pass++;
        n_checks++; if (st_valid !== 1'b0) $display("FAIL reset_st_valid got %b want 0", st_valid); else n_pass++;
        n_checks++; if ({ld_done, last_done, busy} !== 3'b000)
            $display("FAIL reset_pulses_busy got %b want 000", {ld_done, last_done, busy}); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Runs one block from IDLE back to IDLE, checking handshakes, data and pulses cycle by cycle.
    task automatic run_block(input string name, input bit tr, input bit lq, input bit last,
                             input int ld_pct, input int st_pct, input bit strict);
        int ldn, stn, ld_last_k, ldd_cnt;
        bit done, held_v;
        logic [N*BW-1:0] held, exp_row;
        logic [BWO:0] inst;
        ldn = 0; stn = 0; ld_last_k = -10; ldd_cnt = 0; done = 0; held_v = 0; held = '0;
        inst = make_inst(last, tr, lq);
        for (int k = 0; k < 300 && !done; k++) begin
            step_valid = (k == 0);
            step_inst  = inst;
            ld_valid   = (ldn < N) && ($urandom_range(99) < 32'(ld_pct));
            ld_row     = ld_valid ? mat_row(ldn) : N*BW'($urandom);
            st_ready   = ($urandom_range(99) < 32'(st_pct));
            @(negedge clk);
            if (stn == N) begin
                done = 1;
                n_checks++; if (step_ready !== 1'b1 || busy !== 1'b0)
                    $display("FAIL %s end_idle got ready=%b busy=%b want 1/0", name, step_ready, busy); else n_pass++;
                n_checks++; if (last_done !== last)
                    $display("FAIL %s last_done got %b want %b", name, last_done, last); else n_pass++;
                n_checks++; if (ldd_cnt != int'(lq) || ld_done !== 1'b0)
                    $display("FAIL %s ld_done_count got %0d want %0d", name, ldd_cnt, int'(lq)); else n_pass++;
                if (strict) begin
                    n_checks++; if (k != (lq ? 2*N+1 : N+1))
                        $display("FAIL %s ready_again_cycle got t+%0d want t+%0d", name, k, lq ? 2*N+1 : N+1); else n_pass++;
                end
            end else begin
                if (k == 0) begin
                    n_checks++; if (step_ready !== 1'b1) $display("FAIL %s step_accept got %b want 1", name, step_ready); else n_pass++;
                end else begin
                    n_checks++; if (busy !== 1'b1 || step_ready !== 1'b0)
                        $display("FAIL %s busy got busy=%b ready=%b want 1/0", name, busy, step_ready); else n_pass++;
                end
                n_checks++; if (last_done !== 1'b0) $display("FAIL %s early_last_done got %b want 0", name, last_done); else n_pass++;
                if (!lq) begin
                    n_checks++; if (ld_ready !== 1'b0) $display("FAIL %s zf_ld_ready got %b want 0", name, ld_ready); else n_pass++;
                end
                if (ld_done) begin
                    ldd_cnt++;
                    n_checks++; if (!lq || ldn != N || k != ld_last_k + 1)
                        $display("FAIL %s ld_done_time got t+%0d want t+%0d", name, k, ld_last_k + 1); else n_pass++;
                end
                if (ld_ready && ld_valid) begin
                    if (strict && ldn == 0) begin
                        n_checks++; if (k != 1) $display("FAIL %s first_load_cycle got t+%0d want t+1", name, k); else n_pass++;
                    end
                    ld_last_k = k;
                    ldn++;
                end
                if (st_valid) begin
                    exp_row = exp_store(stn, tr, lq);
                    n_checks++; if (st_row !== exp_row)
                        $display("FAIL %s st_row%0d got %h want %h", name, stn, st_row, exp_row); else n_pass++;
                    if (held_v) begin
                        n_checks++; if (st_row !== held)
                            $display("FAIL %s stall_stable got %h want %h", name, st_row, held); else n_pass++;
                    end
                    n_checks++; if (lq && ldn != N)
                        $display("FAIL %s store_before_load got loads=%0d want %0d", name, ldn, N); else n_pass++;
                    held_v = !st_ready;
                    held   = st_row;
                    if (st_ready) stn++;
                end
            end
            @(posedge clk); #1;
        end
        step_valid = 1'b0; ld_valid = 1'b0; st_ready = 1'b0;
        n_checks++; if (!done) $display("FAIL %s timeout got stores=%0d want %0d", name, stn, N); else n_pass++;
    endtask

    task automatic test_load_pass();
        set_pattern();
        run_block("load_pass", 1'b0, 1'b1, 1'b1, 100, 100, 1'b1);
    endtask

    task automatic test_load_transpose();
        set_pattern();
        run_block("load_transpose", 1'b1, 1'b1, 1'b1, 100, 100, 1'b1);
    endtask

    task automatic test_zero_fill();
        set_pattern();
        run_block("zero_fill", 1'b0, 1'b0, 1'b0, 60, 100, 1'b1);
    endtask

    task automatic test_backpressure();
        set_pattern();
        run_block("backpressure", 1'b1, 1'b1, 1'b1, 100, 50, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            set_random();
            run_block("random", 1'($urandom), 1'($urandom), 1'($urandom), 70, 60, 1'b0);
        end
    endtask

    task automatic test_reset_mid_load();
        for (int k = 0; k < 14; k++) begin
            step_valid = (k == 0);
            step_inst  = make_inst(1'b1, 1'b0, 1'b1);
            ld_valid   = 1'b1;
            ld_row     = N*BW'($urandom);
            st_ready   = 1'b1;
            rst        = (k == 3);
            @(negedge clk);
            if (k == 1 || k == 2) begin
                n_checks++; if (ld_ready !== 1'b1) $display("FAIL midrst_load%0d got %b want 1", k, ld_ready); else n_pass++;
            end
            if (k == 4) begin
                n_checks++; if (busy !== 1'b0 || step_ready !== 1'b1)
                    $display("FAIL midrst_idle got busy=%b ready=%b want 0/1", busy, step_ready); else n_pass++;
            end
            if (k >= 4) begin
                n_checks++; if (ld_ready !== 1'b0) $display("FAIL midrst_ld_ready got %b want 0", ld_ready); else n_pass++;
            end
            n_checks++; if (ld_done !== 1'b0 || last_done !== 1'b0)
                $display("FAIL midrst_pulse got ld_done=%b last_done=%b want 0/0", ld_done, last_done); else n_pass++;
            n_checks++; if (st_valid !== 1'b0) $display("FAIL midrst_st_valid got %b want 0", st_valid); else n_pass++;
            @(posedge clk); #1;
        end
        rst = 1'b0; ld_valid = 1'b0; step_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int nsteps, ldn, stc;
        logic [N*BW-1:0] exp_row;
        bit exp_busy;
        set_pattern();
        nsteps = 0; ldn = 0; stc = 0;
        ld_valid = 1'b1; ld_row = mat_row(0); step_valid = 1'b0; st_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++; if (ld_ready !== 1'b0 || busy !== 1'b0)
                $display("FAIL holdoff got ld_ready=%b busy=%b want 0/0", ld_ready, busy); else n_pass++;
            @(posedge clk); #1;
        end
        for (int k = 0; k < 19; k++) begin
            step_valid = (nsteps < 2);
            step_inst  = make_inst(nsteps == 1, nsteps == 1, 1'b1);
            ld_valid   = 1'b1;
            ld_row     = mat_row(ldn);
            st_ready   = 1'b1;
            @(negedge clk);
            exp_busy = !(k == 0 || k == 9 || k == 18);
            n_checks++; if (busy !== exp_busy) $display("FAIL b2b_busy_t%0d got %b want %b", k, busy, exp_busy); else n_pass++;
            if (k == 0) begin
                n_checks++; if (ld_ready !== 1'b0) $display("FAIL b2b_accept_cycle_ld got %b want 0", ld_ready); else n_pass++;
            end
            if (k == 1) begin
                n_checks++; if (ld_ready !== 1'b1) $display("FAIL b2b_row0_accept got %b want 1", ld_ready); else n_pass++;
            end
            if (k == 9) begin
                n_checks++; if (last_done !== 1'b0 || step_ready !== 1'b1)
                    $display("FAIL b2b_gap got last_done=%b ready=%b want 0/1", last_done, step_ready); else n_pass++;
            end
            if (k == 18) begin
                n_checks++; if (last_done !== 1'b1 || stc != 2*N)
                    $display("FAIL b2b_end got last_done=%b stores=%0d want 1/%0d", last_done, stc, 2*N); else n_pass++;
            end
            if (step_valid && step_ready) nsteps++;
            if (ld_valid && ld_ready) ldn = (ldn + 1) % N;
            if (st_valid) begin
                exp_row = exp_store(stc % N, stc >= N, 1'b1);
                n_checks++; if (st_row !== exp_row)
                    $display("FAIL b2b_st_row%0d got %h want %h", stc, st_row, exp_row); else n_pass++;
                if (st_ready) stc++;
            end
            @(posedge clk); #1;
        end
        step_valid = 1'b0; ld_valid = 1'b0; st_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_pass();
        test_load_transpose();
        test_zero_fill();
        test_backpressure();
        test_random();
        test_reset_mid_load();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
